// File: rtl/sysconf_regs.sv
// sysconf_regs: bank of num_regs 32-bit configuration words behind a
// single-address command/value port. A write in IDLE is a command word
// (SELECT / ARM / LOCK / STATUS); the write that follows an accepted ARM is
// the value for the armed entry. data_out is registered and read back with
// a plain read strobe.
module sysconf_regs #(
    parameter int                      num_regs  = 4,
    parameter int                      idx_width = 4,
    parameter logic [num_regs*32-1:0]  init_vals = {32'h0, 32'h4000, 32'h30000, 32'h40000},
    parameter logic [num_regs-1:0]     wr_mask   = 4'b1110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack
);

    typedef enum logic {IDLE, ARMED} state_t;

    localparam logic [1:0] OP_SELECT = 2'b00;
    localparam logic [1:0] OP_ARM    = 2'b01;
    localparam logic [1:0] OP_LOCK   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;

    state_t                 state_q, state_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic [31:0]            dout_q, dout_d;
    logic [idx_width-1:0]   wr_idx_q, wr_idx_d;
    logic                   value_wr;

    logic [1:0]             op;
    logic [idx_width-1:0]   idx;
    logic [31:0]            entry_val [num_regs];
    logic [31:0]            sel_val;
    logic                   sel_hit;
    logic                   sel_wmask;

    assign op       = data_in[31:30];
    assign idx      = data_in[idx_width-1:0];
    assign ack      = stb;
    assign data_out = dout_q;

    // Storage: one register per entry; read-only entries never see a write
    // enable, so they hold their reset value forever.
    genvar gi;
    generate
        for (gi = 0; gi < num_regs; gi++) begin : g_entry
            logic [31:0] entry_q;

            // Entry register: reload on reset, capture data_in on an armed value write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= init_vals[32*gi +: 32];
                end else if (value_wr && wr_mask[gi] && (wr_idx_q == idx_width'(gi))) begin
                    entry_q <= data_in;
                end
            end

            assign entry_val[gi] = entry_q;
        end
    endgenerate

    // Index lookup: out-of-range indices match no entry and yield zero
    always_comb begin
        sel_val   = '0;
        sel_hit   = 1'b0;
        sel_wmask = 1'b0;
        for (int i = 0; i < num_regs; i++) begin
            if (idx == idx_width'(i)) begin
                sel_val   = entry_val[i];
                sel_hit   = 1'b1;
                sel_wmask = wr_mask[i];
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    // Next-state: only write strobes change anything; reads are side-effect free
    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        err_d    = err_q;
        dout_d   = dout_q;
        wr_idx_d = wr_idx_q;
        value_wr = 1'b0;
        if (stb && we) begin
            if (state_q == ARMED) begin
                // Whole word is the value; no op decode, so LOCK cannot sneak in here
                value_wr = 1'b1;
                dout_d   = data_in;
                state_d  = IDLE;
            end else begin
                case (op)
                    OP_SELECT: dout_d = sel_val;
                    OP_ARM: begin
                        if (sel_hit && sel_wmask && !locked_q) begin
                            wr_idx_d = idx;
                            state_d  = ARMED;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_LOCK: locked_d = 1'b1;
                    OP_STATUS: begin
                        // Capture err before the read-to-clear takes effect
                        dout_d = {28'b0, (state_q == ARMED), locked_q, err_q, 1'b1};
                        err_d  = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sysconf_regs.sv
// Bench for sysconf_regs: transaction-level reference model, per-cycle
// comparison of data_out/ack, and directed reads with hand-computed values.
module tb_sysconf_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        ack;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] INIT [4] = '{32'h40000, 32'h30000, 32'h4000, 32'h0};
    localparam logic [3:0]  WMASK    = 4'b1110;

    sysconf_regs dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb      (stb),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    // Reference model: what software should observe, transaction by transaction
    logic [31:0] m_entry [4];
    logic        m_armed;
    int          m_widx;
    logic        m_locked;
    logic        m_err;
    logic [31:0] m_dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_entry[i] = INIT[i];
            m_armed  = 1'b0;
            m_widx   = 0;
            m_locked = 1'b0;
            m_err    = 1'b0;
            m_dout   = '0;
        end else if (stb && we) begin
            if (m_armed) begin
                m_entry[m_widx] = data_in;
                m_dout  = data_in;
                m_armed = 1'b0;
            end else begin
                int k;
                k = int'(data_in[3:0]);
                case (data_in[31:30])
                    2'd0: m_dout = (k < 4) ? m_entry[k] : 32'h0;
                    2'd1: begin
                        if (k < 4 && WMASK[k] && !m_locked) begin
                            m_armed = 1'b1;
                            m_widx  = k;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    2'd2: m_locked = 1'b1;
                    default: begin
                        m_dout = 32'h1 + (m_err ? 32'h2 : 32'h0) + (m_locked ? 32'h4 : 32'h0)
                               + (m_armed ? 32'h8 : 32'h0);
                        m_err  = 1'b0;
                    end
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Per-cycle comparison, in the stable high phase after the model has updated
    always @(posedge clk) begin
        #2;
        check("cycle data_out", data_out, m_dout);
        check("cycle ack", {31'b0, ack}, {31'b0, stb});
    end

    task automatic cmd(input logic [31:0] w);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; data_in = w;
        $display("write %h", w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stb = 1'b0; we = 1'b1; data_in = 32'h4000_0001;
        end
    endtask

    task automatic rd(input string name, input logic [31:0] exp);
        @(negedge clk);
        stb = 1'b1; we = 1'b0; data_in = 32'h4000_0002;
        @(posedge clk);
        #2;
        $display("read  %h (expect %h)", data_out, exp);
        check(name, data_out, exp);
        check({name, " ack"}, {31'b0, ack}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        #2;
        check("reset data_out", data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset");
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        check("power-on data_out", data_out, 32'h0);

        // SELECT / read latency
        cmd(32'h0000_0001);             rd("select 1", 32'h30000);

        // ARM + value write on a writable entry
        cmd(32'h4000_0003); cmd(32'hDEAD_BEEF);
        rd("value echo", 32'hDEAD_BEEF);
        cmd(32'h0000_0003);             rd("select 3", 32'hDEAD_BEEF);
        cmd(32'hC000_0000);             rd("status clean", 32'h1);

        // ARM of read-only entry sets err; STATUS clears it
        cmd(32'h4000_0000);
        cmd(32'hC000_0000);             rd("status err", 32'h3);
        cmd(32'hC000_0000);             rd("status cleared", 32'h1);
        cmd(32'h0000_0000);             rd("select 0 ro", 32'h40000);

        // Out-of-range SELECT: zero, no err; out-of-range ARM: err
        cmd(32'h0000_0009);             rd("select 9", 32'h0);
        cmd(32'hC000_0000);             rd("status after sel9", 32'h1);
        cmd(32'h4000_0007);
        cmd(32'hC000_0000);             rd("status arm oor", 32'h3);

        // LOCK blocks new ARMs; repeat LOCK harmless
        cmd(32'h8000_0000); cmd(32'h4000_0002);
        cmd(32'hC000_0000);             rd("status locked err", 32'h7);
        cmd(32'h0000_0002);             rd("select 2 locked", 32'h4000);
        cmd(32'h8000_0000);
        cmd(32'hC000_0000);             rd("status relock", 32'h5);

        // Reset clears lock
        do_reset();
        cmd(32'hC000_0000);             rd("status post reset", 32'h1);

        // ARM with interleaved reads and idle cycles, then value
        cmd(32'h0000_0001);             rd("select 1 again", 32'h30000);
        cmd(32'h4000_0002);
        rd("armed read a", 32'h30000);
        idle(2);
        rd("armed read b", 32'h30000);
        rd("armed read c", 32'h30000);
        cmd(32'h0000_8000);             rd("value 8000", 32'h8000);
        cmd(32'h0000_0002);             rd("select 2 new", 32'h8000);

        // Reset while ARMED discards the pending write and returns to IDLE
        cmd(32'h4000_0002);
        do_reset();
        cmd(32'h0000_1234);             rd("idle after reset", 32'h0);
        cmd(32'h0000_0002);             rd("select 2 init", 32'h4000);
        cmd(32'h0000_0003);             rd("select 3 init", 32'h0);

        idle(2);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
